// File: rtl/voice_allocator_pkg.sv
// Shared constants and types for the polyphony voice allocator and its neighbours
// (arpeggiator, synth top).
package voice_allocator_pkg;

    localparam int NUM_VOICES_DEF = 8;
    localparam int AGE_W_DEF      = 8;
    localparam int GAP_CYCLES_DEF = 2048;

    typedef logic [6:0] note_t;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SCAN   = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;
    localparam logic [1:0] ST_GAP    = 2'd3;

endpackage

// File: rtl/voice_allocator_if.sv
// Note-event handshake between the event source (master) and the allocator (slave).
interface voice_allocator_if;
    import voice_allocator_pkg::*;

    logic  ev_valid;
    logic  ev_ready;
    logic  ev_note_on;
    note_t ev_note;

    modport master (output ev_valid, output ev_note_on, output ev_note, input ev_ready);
    modport slave  (input ev_valid, input ev_note_on, input ev_note, output ev_ready);
endinterface

// File: rtl/voice_allocator_select.sv
// Scan comparator: sees one voice per cycle and keeps the matching voice, the oldest idle
// voice and the oldest active voice. Strict '>' keeps the lowest index on age ties.
module voice_allocator_select
    import voice_allocator_pkg::*;
#(
    parameter int NUM_VOICES = NUM_VOICES_DEF,
    parameter int AGE_W      = AGE_W_DEF,
    localparam int VW        = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             clear,
    input  logic             en,
    input  logic [VW-1:0]    idx,
    input  logic             key,
    input  note_t            freq,
    input  logic [AGE_W-1:0] age,
    input  note_t            note,
    output logic             match_valid,
    output logic [VW-1:0]    match_idx,
    output logic             idle_valid,
    output logic [VW-1:0]    idle_idx,
    output logic [VW-1:0]    act_idx
);
    logic             match_valid_q, match_valid_d, idle_valid_q, idle_valid_d;
    logic             act_valid_q, act_valid_d;
    logic [VW-1:0]    match_idx_q, match_idx_d, idle_idx_q, idle_idx_d, act_idx_q, act_idx_d;
    logic [AGE_W-1:0] idle_age_q, idle_age_d, act_age_q, act_age_d;
    logic             match_hit_s, idle_hit_s, act_hit_s;

    // Does the voice under scan beat the current holder of each candidate slot?
    always_comb begin
        match_hit_s = en & key & (freq == note) & ~match_valid_q;
        idle_hit_s  = en & ~key & (~idle_valid_q | (age > idle_age_q));
        act_hit_s   = en & key & (~act_valid_q | (age > act_age_q));
    end

    // Candidate update: clear on scan entry, otherwise take the winner or hold.
    always_comb begin
        match_valid_d = match_valid_q;
        match_idx_d   = match_idx_q;
        idle_valid_d  = idle_valid_q;
        idle_idx_d    = idle_idx_q;
        idle_age_d    = idle_age_q;
        act_valid_d   = act_valid_q;
        act_idx_d     = act_idx_q;
        act_age_d     = act_age_q;
        if (clear) begin
            match_valid_d = 1'b0;
            match_idx_d   = '0;
            idle_valid_d  = 1'b0;
            idle_idx_d    = '0;
            idle_age_d    = '0;
            act_valid_d   = 1'b0;
            act_idx_d     = '0;
            act_age_d     = '0;
        end else begin
            if (match_hit_s) begin
                match_valid_d = 1'b1;
                match_idx_d   = idx;
            end else begin
                match_valid_d = match_valid_q;
            end
            if (idle_hit_s) begin
                idle_valid_d = 1'b1;
                idle_idx_d   = idx;
                idle_age_d   = age;
            end else begin
                idle_valid_d = idle_valid_q;
            end
            if (act_hit_s) begin
                act_valid_d = 1'b1;
                act_idx_d   = idx;
                act_age_d   = age;
            end else begin
                act_valid_d = act_valid_q;
            end
        end
    end

    // Candidate registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            match_valid_q <= 1'b0;
            match_idx_q   <= '0;
            idle_valid_q  <= 1'b0;
            idle_idx_q    <= '0;
            idle_age_q    <= '0;
            act_valid_q   <= 1'b0;
            act_idx_q     <= '0;
            act_age_q     <= '0;
        end else begin
            match_valid_q <= match_valid_d;
            match_idx_q   <= match_idx_d;
            idle_valid_q  <= idle_valid_d;
            idle_idx_q    <= idle_idx_d;
            idle_age_q    <= idle_age_d;
            act_valid_q   <= act_valid_d;
            act_idx_q     <= act_idx_d;
            act_age_q     <= act_age_d;
        end
    end

    assign match_valid = match_valid_q;
    assign match_idx   = match_idx_q;
    assign idle_valid  = idle_valid_q;
    assign idle_idx    = idle_idx_q;
    assign act_idx     = act_idx_q;
endmodule

// File: rtl/voice_allocator.sv
// Polyphony scheduler: assigns note events to voices (idle first, else steal the oldest)
// and forces a key_on low gap on retrigger/steal so slow-clocked envelopes see the edge.
module voice_allocator
    import voice_allocator_pkg::*;
#(
    parameter int NUM_VOICES = NUM_VOICES_DEF,
    parameter int AGE_W      = AGE_W_DEF,
    parameter int GAP_CYCLES = GAP_CYCLES_DEF
) (
    input  logic                    Clk,
    input  logic                    Reset,
    voice_allocator_if.slave        ev,
    input  logic                    panic,
    output logic [NUM_VOICES-1:0]   voice_key,
    output logic [NUM_VOICES*7-1:0] voice_freq,
    output logic                    steal,
    output logic                    busy
);
    localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};

    logic [1:0]                        state_q, state_d;
    logic [VW-1:0]                     scan_idx_q, scan_idx_d, target_q, target_d;
    logic                              ev_on_q, ev_on_d;
    note_t                             ev_note_q, ev_note_d;
    logic [NUM_VOICES-1:0]             key_q, key_d;
    logic [NUM_VOICES-1:0][6:0]        freq_q, freq_d;
    logic [NUM_VOICES-1:0][AGE_W-1:0]  age_q, age_d;
    logic [GW-1:0]                     gap_q, gap_d;

    logic          ready_s, sel_clear_s, sel_en_s, retrig_s, steal_hit_s;
    logic          sel_match_valid_s, sel_idle_valid_s;
    logic [VW-1:0] sel_match_idx_s, sel_idle_idx_s, sel_act_idx_s, tgt_s;

    voice_allocator_select #(.NUM_VOICES(NUM_VOICES), .AGE_W(AGE_W)) u_select (
        .Clk         (Clk),
        .Reset       (Reset),
        .clear       (sel_clear_s),
        .en          (sel_en_s),
        .idx         (scan_idx_q),
        .key         (key_q[scan_idx_q]),
        .freq        (freq_q[scan_idx_q]),
        .age         (age_q[scan_idx_q]),
        .note        (ev_note_q),
        .match_valid (sel_match_valid_s),
        .match_idx   (sel_match_idx_s),
        .idle_valid  (sel_idle_valid_s),
        .idle_idx    (sel_idle_idx_s),
        .act_idx     (sel_act_idx_s)
    );

    // Note-on target choice: retrigger a match, else take an idle voice, else steal.
    always_comb begin
        if (sel_match_valid_s) begin
            tgt_s = sel_match_idx_s; retrig_s = 1'b1; steal_hit_s = 1'b0;
        end else if (sel_idle_valid_s) begin
            tgt_s = sel_idle_idx_s;  retrig_s = 1'b0; steal_hit_s = 1'b0;
        end else begin
            tgt_s = sel_act_idx_s;   retrig_s = 1'b1; steal_hit_s = 1'b1;
        end
    end

    // Allocation FSM; panic overrides every state and leaves freq/ages alone.
    always_comb begin
        state_d     = state_q;
        scan_idx_d  = scan_idx_q;
        target_d    = target_q;
        ev_on_d     = ev_on_q;
        ev_note_d   = ev_note_q;
        key_d       = key_q;
        freq_d      = freq_q;
        age_d       = age_q;
        gap_d       = gap_q;
        sel_clear_s = 1'b0;
        sel_en_s    = 1'b0;
        if (panic) begin
            key_d   = '0;
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ev.ev_valid) begin
                        ev_on_d     = ev.ev_note_on;
                        ev_note_d   = ev.ev_note;
                        scan_idx_d  = '0;
                        sel_clear_s = 1'b1;
                        state_d     = ST_SCAN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_SCAN: begin
                    sel_en_s = 1'b1;
                    if (scan_idx_q == VW'(NUM_VOICES - 1)) begin
                        state_d = ST_COMMIT;
                    end else begin
                        scan_idx_d = scan_idx_q + VW'(1);
                    end
                end
                ST_COMMIT: begin
                    state_d = ST_IDLE;
                    if (ev_on_q) begin
                        for (int v = 0; v < NUM_VOICES; v++) begin
                            if (VW'(v) == tgt_s) begin
                                age_d[v] = '0;
                            end else if (age_q[v] != AGE_MAX) begin
                                age_d[v] = age_q[v] + AGE_W'(1);
                            end else begin
                                age_d[v] = age_q[v];
                            end
                        end
                        freq_d[tgt_s] = ev_note_q;
                        target_d      = tgt_s;
                        if (retrig_s) begin
                            key_d[tgt_s] = 1'b0;
                            gap_d        = GW'(GAP_CYCLES - 1);
                            state_d      = ST_GAP;
                        end else begin
                            key_d[tgt_s] = 1'b1;
                        end
                    end else if (sel_match_valid_s) begin
                        key_d[sel_match_idx_s] = 1'b0;
                        age_d[sel_match_idx_s] = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_GAP: begin
                    if (gap_q == GW'(0)) begin
                        key_d[target_q] = 1'b1;
                        state_d         = ST_IDLE;
                    end else begin
                        gap_d = gap_q - GW'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Allocator state registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            scan_idx_q <= '0;
            target_q   <= '0;
            ev_on_q    <= 1'b0;
            ev_note_q  <= '0;
            key_q      <= '0;
            freq_q     <= '0;
            age_q      <= '0;
            gap_q      <= '0;
        end else begin
            state_q    <= state_d;
            scan_idx_q <= scan_idx_d;
            target_q   <= target_d;
            ev_on_q    <= ev_on_d;
            ev_note_q  <= ev_note_d;
            key_q      <= key_d;
            freq_q     <= freq_d;
            age_q      <= age_d;
            gap_q      <= gap_d;
        end
    end

    assign ready_s     = (state_q == ST_IDLE) & ~panic;
    assign ev.ev_ready = ready_s;
    assign busy        = ~ready_s;
    assign voice_key   = key_q;
    assign voice_freq  = freq_q;
    assign steal       = (state_q == ST_COMMIT) & ev_on_q & steal_hit_s & ~panic;
endmodule
